// File: rtl/vga_palette_ctrl.sv
// Two-entry RRRGGGBB palette in front of the VGA DAC, with a 2-stage pixel/sync pipeline.
// Palette updates are staged and only committed while no visible pixel is in flight.
module vga_palette_ctrl #(
  parameter logic [7:0] COLOR_0_RST = 8'h1C,
  parameter logic [7:0] COLOR_1_RST = 8'hFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       data,
  input  logic       active,
  input  logic       vblank,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       cfg_valid,
  input  logic       cfg_sel,
  input  logic [7:0] cfg_color,
  output logic       cfg_ready,
  output logic       pending,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       hsync,
  output logic       vsync
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t     state;
  state_t     next_state;
  logic       accept;
  logic       window;
  logic [7:0] pal0;
  logic [7:0] pal1;
  logic       stg_sel;
  logic [7:0] stg_color;
  logic       data_d1;
  logic       active_d1;
  logic       active_d2;
  logic       hsync_d1;
  logic       vsync_d1;
  logic [7:0] code;

  function automatic logic [23:0] expand(input logic [7:0] c);
    return {c[7:5], 5'b00000, c[4:2], 5'b00000, c[1:0], 6'b000000};
  endfunction

  // Config FSM next-state logic; the window excludes both pipeline stages holding a visible pixel.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    window     = vblank & ~active_d1 & ~active_d2;
    case (state)
      S_IDLE: begin
        if (cfg_valid) begin
          accept     = 1'b1;
          next_state = S_WAIT;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        if (window) begin
          next_state = S_COMMIT;
        end else begin
          next_state = S_WAIT;
        end
      end
      S_COMMIT: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // State register, registered handshake outputs and staging registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cfg_ready <= 1'b1;
      pending   <= 1'b0;
      stg_sel   <= 1'b0;
      stg_color <= 8'h00;
    end else begin
      state     <= next_state;
      cfg_ready <= (next_state == S_IDLE);
      pending   <= (next_state != S_IDLE);
      if (accept) begin
        stg_sel   <= cfg_sel;
        stg_color <= cfg_color;
      end
    end
  end

  // Palette storage, written only on leaving COMMIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pal0 <= COLOR_0_RST;
      pal1 <= COLOR_1_RST;
    end else if (state == S_COMMIT) begin
      if (stg_sel) begin
        pal1 <= stg_color;
      end else begin
        pal0 <= stg_color;
      end
    end
  end

  assign code = data_d1 ? pal1 : pal0;

  // Two-stage pixel and sync pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_d1   <= 1'b0;
      active_d1 <= 1'b0;
      active_d2 <= 1'b0;
      hsync_d1  <= 1'b0;
      vsync_d1  <= 1'b0;
      hsync     <= 1'b0;
      vsync     <= 1'b0;
      red       <= 8'h00;
      green     <= 8'h00;
      blue      <= 8'h00;
    end else begin
      data_d1   <= data;
      active_d1 <= active;
      active_d2 <= active_d1;
      hsync_d1  <= hsync_in;
      vsync_d1  <= vsync_in;
      hsync     <= hsync_d1;
      vsync     <= vsync_d1;
      if (active_d1) begin
        {red, green, blue} <= expand(code);
      end else begin
        {red, green, blue} <= 24'h000000;
      end
    end
  end

endmodule

// File: tb/tb_vga_palette_ctrl.sv
// Directed bench for vga_palette_ctrl: pixel expansion, sync delay, tear-free palette commits, reset.
module tb_vga_palette_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       data, active, vblank, hsync_in, vsync_in;
  logic       cfg_valid, cfg_sel;
  logic [7:0] cfg_color;
  logic       cfg_ready, pending;
  logic [7:0] red, green, blue;
  logic       hsync, vsync;

  int total = 0;
  int passed = 0;

  vga_palette_ctrl dut (
    .clk(clk), .reset_n(reset_n), .data(data), .active(active), .vblank(vblank),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .cfg_valid(cfg_valid), .cfg_sel(cfg_sel),
    .cfg_color(cfg_color), .cfg_ready(cfg_ready), .pending(pending),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] rgb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return {8'h00, r, g, b};
  endfunction

  initial begin
    reset_n = 1'b0; data = 1'b0; active = 1'b0; vblank = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; cfg_valid = 1'b0; cfg_sel = 1'b0; cfg_color = 8'h00;
    step(2);
    check("rst_rgb", {8'h00, red, green, blue}, rgb(8'd0, 8'd0, 8'd0));
    check("rst_ready", {31'd0, cfg_ready}, 32'd1);
    check("rst_pending", {31'd0, pending}, 32'd0);
    check("rst_sync", {30'd0, hsync, vsync}, 32'd0);
    reset_n = 1'b1;
    step(1);

    // 1: default palette, sync lag
    active = 1'b1; data = 1'b0; hsync_in = 1'b1;
    step(1);
    check("hsync_lag1", {31'd0, hsync}, 32'd0);
    data = 1'b1; hsync_in = 1'b0; vsync_in = 1'b1;
    step(1);
    check("pix_green", {8'h00, red, green, blue}, rgb(8'd0, 8'd224, 8'd0));
    check("hsync_lag2", {31'd0, hsync}, 32'd1);
    check("vsync_lag1", {31'd0, vsync}, 32'd0);
    step(1);
    check("pix_white", {8'h00, red, green, blue}, rgb(8'd224, 8'd224, 8'd192));
    check("sync_after", {30'd0, hsync, vsync}, 32'd1);
    vsync_in = 1'b0;

    // 2: blanked pixel
    active = 1'b0; data = 1'b1;
    step(2);
    check("blank_rgb", {8'h00, red, green, blue}, rgb(8'd0, 8'd0, 8'd0));

    // 3: commit during vblank with empty pipeline
    vblank = 1'b1; cfg_valid = 1'b1; cfg_sel = 1'b0; cfg_color = 8'hE0;
    check("t3_ready_N", {31'd0, cfg_ready}, 32'd1);
    step(1);
    cfg_valid = 1'b0;
    check("t3_pend_N1", {30'd0, pending, cfg_ready}, 32'd2);
    step(1);
    check("t3_pend_N2", {30'd0, pending, cfg_ready}, 32'd2);
    step(1);
    check("t3_ready_N3", {30'd0, pending, cfg_ready}, 32'd1);
    vblank = 1'b0; active = 1'b1; data = 1'b0;
    step(2);
    check("t3_red", {8'h00, red, green, blue}, rgb(8'd224, 8'd0, 8'd0));

    // 4: write accepted during active video waits for vblank
    cfg_valid = 1'b1; cfg_sel = 1'b0; cfg_color = 8'h03;
    step(1);
    cfg_valid = 1'b0;
    step(4);
    check("t4_pend_frame", {30'd0, pending, cfg_ready}, 32'd2);
    check("t4_rgb_frame", {8'h00, red, green, blue}, rgb(8'd224, 8'd0, 8'd0));
    active = 1'b0;
    step(3);
    check("t4_pend_hblank", {30'd0, pending, cfg_ready}, 32'd2);
    vblank = 1'b1;
    step(1);
    check("t4_commit", {30'd0, pending, cfg_ready}, 32'd2);
    step(1);
    check("t4_idle", {30'd0, pending, cfg_ready}, 32'd1);
    vblank = 1'b0; active = 1'b1; data = 1'b0;
    step(2);
    check("t4_blue", {8'h00, red, green, blue}, rgb(8'd0, 8'd0, 8'd192));

    // 5: vblank rises with last active pixel
    cfg_valid = 1'b1; cfg_sel = 1'b0; cfg_color = 8'h1C;
    step(1);
    cfg_valid = 1'b0;
    vblank = 1'b1;
    step(1);
    active = 1'b0;
    step(1);
    check("t5_last_old", {8'h00, red, green, blue}, rgb(8'd0, 8'd0, 8'd192));
    check("t5_pend_a", {30'd0, pending, cfg_ready}, 32'd2);
    step(2);
    check("t5_not_early", {30'd0, pending, cfg_ready}, 32'd2);
    step(1);
    check("t5_done", {30'd0, pending, cfg_ready}, 32'd1);
    vblank = 1'b0; active = 1'b1; data = 1'b0;
    step(2);
    check("t5_new", {8'h00, red, green, blue}, rgb(8'd0, 8'd224, 8'd0));

    // back-to-back writes to entry 1: last one wins
    active = 1'b0; vblank = 1'b1;
    step(2);
    cfg_valid = 1'b1; cfg_sel = 1'b1; cfg_color = 8'h03;
    step(1);
    cfg_color = 8'hE0;
    step(2);
    check("b2b_ready", {31'd0, cfg_ready}, 32'd1);
    step(1);
    cfg_valid = 1'b0;
    step(2);
    vblank = 1'b0; active = 1'b1; data = 1'b1;
    step(2);
    check("b2b_last", {8'h00, red, green, blue}, rgb(8'd224, 8'd0, 8'd0));

    // 6: reset while in WAIT
    cfg_valid = 1'b1; cfg_sel = 1'b1; cfg_color = 8'h00;
    step(1);
    cfg_valid = 1'b0;
    step(1);
    check("t6_pend_pre", {31'd0, pending}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_hs", {30'd0, pending, cfg_ready}, 32'd1);
    check("t6_rst_rgb", {8'h00, red, green, blue}, rgb(8'd0, 8'd0, 8'd0));
    step(1);
    reset_n = 1'b1;
    vblank = 1'b1; active = 1'b0;
    step(4);
    vblank = 1'b0; active = 1'b1; data = 1'b1;
    step(2);
    check("t6_pal1_ff", {8'h00, red, green, blue}, rgb(8'd224, 8'd224, 8'd192));
    data = 1'b0;
    step(2);
    check("t6_pal0_rst", {8'h00, red, green, blue}, rgb(8'd0, 8'd224, 8'd0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
